// File: rtl/axis_throttle_scheduler.sv
// Drives the throttler's log2 decimation: software request plus an automatic FIFO-fill back-off,
// committed only when the stream is idle or on a handshake beat.
module axis_throttle_scheduler #(
    parameter int LEVEL_WIDTH = 16,
    parameter int HIGH_WATER  = 3072,
    parameter int LOW_WATER   = 1024,
    parameter int HOLD_CYCLES = 1024
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [4:0]             log_throttle_req_i,
    input  logic                   auto_en_i,
    input  logic [LEVEL_WIDTH-1:0] fifo_level_i,
    input  logic                   s_tvalid_i,
    input  logic                   beat_i,
    output logic [4:0]             log_throttle_o,
    output logic [4:0]             boost_o,
    output logic                   saturated_o,
    output logic [15:0]            change_count_o
);
    localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TW-1:0] RELOAD = TW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {MANUAL, AUTO_IDLE, AUTO_BACKOFF} state_t;

    state_t          state_q, state_d;
    logic [4:0]      boost_q, boost_d;
    logic [4:0]      lt_q, lt_d;
    logic            sat_q, sat_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [TW-1:0]   timer_q, timer_d;

    logic [5:0]      sum, sum_next;
    logic [4:0]      target;
    logic            lvl_hi, lvl_lo;

    assign sum    = {1'b0, log_throttle_req_i} + {1'b0, boost_q};
    assign target = sum[5] ? 5'd31 : sum[4:0];
    assign lvl_hi = fifo_level_i >= LEVEL_WIDTH'(HIGH_WATER);
    assign lvl_lo = fifo_level_i <= LEVEL_WIDTH'(LOW_WATER);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= MANUAL;
            boost_q <= '0;
            lt_q    <= '0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            boost_q <= boost_d;
            lt_q    <= lt_d;
            sat_q   <= sat_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        boost_d  = boost_q;
        timer_d  = (timer_q != '0) ? timer_q - 1'b1 : timer_q;
        lt_d     = lt_q;
        cnt_d    = cnt_q;

        // Commit uses the pre-step target; a step this cycle commits at a later safe point.
        if (target != lt_q && (beat_i || !s_tvalid_i)) begin
            lt_d  = target;
            cnt_d = cnt_q + 16'd1;
        end

        case (state_q)
            MANUAL: begin
                boost_d = '0;
                timer_d = '0;
                if (auto_en_i) state_d = AUTO_IDLE;
            end
            AUTO_IDLE: begin
                if (timer_q == '0 && lvl_hi) begin
                    boost_d = 5'd1;
                    timer_d = RELOAD;
                    state_d = AUTO_BACKOFF;
                end
            end
            AUTO_BACKOFF: begin
                if (timer_q == '0) begin
                    if (lvl_hi) begin
                        if (target != 5'd31) boost_d = boost_q + 5'd1;
                        timer_d = RELOAD;
                    end else if (lvl_lo) begin
                        boost_d = boost_q - 5'd1;
                        timer_d = RELOAD;
                        if (boost_q == 5'd1) state_d = AUTO_IDLE;
                    end
                end
            end
            default: state_d = MANUAL;
        endcase

        if (state_q != MANUAL && !auto_en_i) begin
            state_d = MANUAL;
            boost_d = '0;
            timer_d = '0;
        end
    end

    // Flags a boost that is pinned by the 31 ceiling (target clipped or stuck at the top).
    assign sum_next = {1'b0, log_throttle_req_i} + {1'b0, boost_d};
    assign sat_d    = (boost_d != '0) && (sum_next >= 6'd31);

    assign log_throttle_o = lt_q;
    assign boost_o        = boost_q;
    assign saturated_o    = sat_q;
    assign change_count_o = cnt_q;
endmodule
